// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// frame/oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int SC_W       = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] MID_SAMPLE  = SC_W'(7);
  localparam logic [SC_W-1:0] LAST_SAMPLE = SC_W'(15);

  localparam int FRAME_BITS = 8;
  localparam int BI_W       = $clog2(FRAME_BITS);

endpackage

// File: rtl/rx_fifo.sv
// Receive byte FIFO: DEPTH entries, first-word fall-through head, occupancy count.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FRAME_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a byte when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);

  // Empty head reads as zero so the unreset storage never reaches the bus.
  assign dout = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_receive_buffer.sv
// 16x-oversampled 8N1 receiver with programmable baud divisor, feeding a
// small byte FIFO and sticky framing/overrun status.
module uart_receive_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic                   RX,
  input  logic [7:0]             DIVISOR,
  input  logic                   RD,
  input  logic                   CLR_ERR,
  output logic [7:0]             DATA_OUT,
  output logic                   DATA_AVAIL,
  output logic                   FULL,
  output logic                   FRAME_ERR,
  output logic                   OVERRUN,
  output logic                   BUSY,
  output logic [$clog2(DEPTH):0] COUNT
);

  logic                  rx_meta;
  logic                  rx_s;
  logic [7:0]            tick_cnt;
  logic                  tick;
  rx_state_t             state, state_next;
  logic [SC_W-1:0]       sc, sc_next;
  logic [BI_W-1:0]       bi, bi_next;
  logic [FRAME_BITS-1:0] shift, shift_next;
  logic                  push;
  logic                  ferr_set;
  logic                  overrun_set;
  logic                  empty;

  // NOTE: non-blocking so rx_s takes the previous rx_meta: two real flop stages.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  assign tick = EN && (tick_cnt == DIVISOR);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)               tick_cnt <= '0;
    else if (!EN || tick)  tick_cnt <= '0;
    else                   tick_cnt <= tick_cnt + 8'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      sc    <= '0;
      bi    <= '0;
      shift <= '0;
    end else begin
      state <= state_next;
      sc    <= sc_next;
      bi    <= bi_next;
      shift <= shift_next;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_next = state;
    sc_next    = sc;
    bi_next    = bi;
    shift_next = shift;
    if (!EN) begin
      state_next = IDLE;
      sc_next    = '0;
      bi_next    = '0;
    end else if (tick) begin
      case (state)
        IDLE: if (!rx_s) begin
          state_next = START;
          sc_next    = '0;
        end
        START: begin
          if (sc == MID_SAMPLE) begin
            if (rx_s) begin
              state_next = IDLE;
            end else begin
              state_next = DATA;
              sc_next    = '0;
              bi_next    = '0;
            end
          end else begin
            sc_next = sc + SC_W'(1);
          end
        end
        DATA: begin
          sc_next = sc + SC_W'(1);
          if (sc == LAST_SAMPLE) begin
            shift_next[bi] = rx_s;
            if (bi == BI_W'(FRAME_BITS - 1)) state_next = STOP;
            else                             bi_next    = bi + BI_W'(1);
          end
        end
        STOP: begin
          sc_next = sc + SC_W'(1);
          if (sc == LAST_SAMPLE) state_next = rx_s ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: if (rx_s) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    BUSY     = (state != IDLE);
    push     = EN && tick && (state == STOP) && (sc == LAST_SAMPLE) && rx_s;
    ferr_set = EN && tick && (state == STOP) && (sc == LAST_SAMPLE) && !rx_s;
  end

  // A full FIFO is never empty, so RD here always frees the slot for the push.
  assign overrun_set = push && FULL && !RD;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (ferr_set)     FRAME_ERR <= 1'b1;
      else if (CLR_ERR) FRAME_ERR <= 1'b0;
      if (overrun_set)  OVERRUN   <= 1'b1;
      else if (CLR_ERR) OVERRUN   <= 1'b0;
    end
  end

  rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FRAME_BITS)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (RD),
    .din   (shift),
    .dout  (DATA_OUT),
    .full  (FULL),
    .empty (empty),
    .count (COUNT)
  );

  assign DATA_AVAIL = !empty;

endmodule

// File: tb/tb_uart_receive_buffer.sv
// Directed bench for uart_receive_buffer: serial frames are driven on RX and
// received bytes are checked against a scoreboard queue as they are read out.
module tb_uart_receive_buffer;

  localparam int DEPTH = 4;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic                   EN;
  logic                   RX;
  logic [7:0]             DIVISOR;
  logic                   RD;
  logic                   CLR_ERR;
  logic [7:0]             DATA_OUT;
  logic                   DATA_AVAIL;
  logic                   FULL;
  logic                   FRAME_ERR;
  logic                   OVERRUN;
  logic                   BUSY;
  logic [$clog2(DEPTH):0] COUNT;

  int         passed = 0;
  int         total  = 0;
  int         hold_low = 0;
  int         rise_c;
  logic [7:0] exp_q [$];

  uart_receive_buffer #(.DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .RX         (RX),
    .DIVISOR    (DIVISOR),
    .RD         (RD),
    .CLR_ERR    (CLR_ERR),
    .DATA_OUT   (DATA_OUT),
    .DATA_AVAIL (DATA_AVAIL),
    .FULL       (FULL),
    .FRAME_ERR  (FRAME_ERR),
    .OVERRUN    (OVERRUN),
    .BUSY       (BUSY),
    .COUNT      (COUNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // RX level at clock index c of a frame with b clocks per bit.
  function automatic logic rx_at(input logic [7:0] d, input logic stop, input int c, input int b);
    if (c < b)                 return 1'b0;
    if (c < 9 * b)             return d[c / b - 1];
    if (c < 10 * b + hold_low) return stop;
    return 1'b1;
  endfunction

  task automatic drive_frame(input logic [7:0] d, input logic stop, input int from_c, input int to_c);
    int   b;
    logic prev;
    b = 16 * (int'(DIVISOR) + 1);
    for (int c = from_c; c < to_c; c++) begin
      prev = DATA_AVAIL;
      RX   = rx_at(d, stop, c, b);
      step(1);
      if (!prev && DATA_AVAIL && rise_c < 0) rise_c = c + 1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    int b;
    b = 16 * (int'(DIVISOR) + 1);
    drive_frame(d, stop, 0, 11 * b + hold_low);
  endtask

  task automatic read_check(input string tag);
    logic [7:0] e;
    e = 8'h00;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check({tag, " avail"}, DATA_AVAIL, 1);
    check(tag, DATA_OUT, e);
    RD = 1'b1;
    step(1);
    RD = 1'b0;
  endtask

  task automatic pulse_clr();
    CLR_ERR = 1'b1;
    step(1);
    CLR_ERR = 1'b0;
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; RX = 1'b1; RD = 1'b0; CLR_ERR = 1'b0; DIVISOR = 8'd0;
    step(3);
    check("rst data_out",   DATA_OUT,   0);
    check("rst data_avail", DATA_AVAIL, 0);
    check("rst full",       FULL,       0);
    check("rst frame_err",  FRAME_ERR,  0);
    check("rst overrun",    OVERRUN,    0);
    check("rst busy",       BUSY,       0);
    check("rst count",      COUNT,      0);
    RST = 1'b0; EN = 1'b1;
    step(4);

    // Single frame at DIVISOR=0, with latency from RX fall to DATA_AVAIL.
    rise_c = -1;
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1);
    check("t1 latency 152..156", (rise_c >= 152 && rise_c <= 156), 1);
    check("t1 count", COUNT, 1);
    check("t1 busy idle", BUSY, 0);
    read_check("t1 data");
    check("t1 avail after rd", DATA_AVAIL, 0);
    check("t1 count after rd", COUNT, 0);

    // Short low glitch at DIVISOR=3 is rejected at the mid-start check.
    EN = 1'b0; step(1); DIVISOR = 8'd3; EN = 1'b1; step(2);
    RX = 1'b0;
    step(12);
    check("t2 busy on glitch", BUSY, 1);
    step(8);
    RX = 1'b1;
    for (int i = 0; i < 64 && BUSY; i++) step(1);
    check("t2 busy back to idle", BUSY, 0);
    check("t2 count", COUNT, 0);
    check("t2 avail", DATA_AVAIL, 0);
    EN = 1'b0; step(1); DIVISOR = 8'd0; EN = 1'b1; step(2);

    // Framing error with a long break, then a valid byte, then clear.
    hold_low = 48;
    send(8'h3C, 1'b0);
    hold_low = 0;
    check("t3 frame_err set", FRAME_ERR, 1);
    check("t3 count", COUNT, 0);
    check("t3 busy", BUSY, 0);
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1);
    check("t3 frame_err sticky", FRAME_ERR, 1);
    read_check("t3 data");
    pulse_clr();
    check("t3 frame_err cleared", FRAME_ERR, 0);

    // Overflow: five bytes into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      send(8'(i), 1'b1);
      if (i == DEPTH) begin
        check("t4 full at depth", FULL, 1);
        check("t4 count at depth", COUNT, DEPTH);
        check("t4 no overrun yet", OVERRUN, 0);
      end
    end
    check("t4 overrun", OVERRUN, 1);
    check("t4 count kept", COUNT, DEPTH);
    for (int i = 0; i < DEPTH; i++) read_check("t4 data");
    check("t4 drained", DATA_AVAIL, 0);
    pulse_clr();
    check("t4 overrun cleared", OVERRUN, 0);

    // Pop on the exact push cycle of a fifth byte while full.
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'h21 + 8'(i));
      send(8'h21 + 8'(i), 1'b1);
    end
    check("t5 full", FULL, 1);
    drive_frame(8'h55, 1'b1, 0, 154);
    check("t5 head before pop", DATA_OUT, exp_q[0]);
    RD = 1'b1;
    drive_frame(8'h55, 1'b1, 154, 155);
    RD = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h55);
    drive_frame(8'h55, 1'b1, 155, 176);
    check("t5 no overrun", OVERRUN, 0);
    check("t5 count", COUNT, DEPTH);
    for (int i = 0; i < DEPTH; i++) read_check("t5 data");
    check("t5 drained", COUNT, 0);

    // Receiver disabled mid-DATA: partial byte is discarded.
    drive_frame(8'hFF, 1'b1, 0, 60);
    check("t6 busy mid frame", BUSY, 1);
    EN = 1'b0;
    drive_frame(8'hFF, 1'b1, 60, 62);
    check("t6 busy after disable", BUSY, 0);
    EN = 1'b1;
    drive_frame(8'hFF, 1'b1, 62, 176);
    check("t6 nothing queued", COUNT, 0);
    exp_q.push_back(8'h42);
    send(8'h42, 1'b1);
    check("t6 count", COUNT, 1);
    read_check("t6 data");

    // Reset mid-frame with data and a sticky flag present.
    send(8'h77, 1'b1);
    hold_low = 48;
    send(8'h3C, 1'b0);
    hold_low = 0;
    check("t7 pre avail", DATA_AVAIL, 1);
    check("t7 pre frame_err", FRAME_ERR, 1);
    drive_frame(8'h99, 1'b1, 0, 80);
    RST = 1'b1;
    #2;
    check("t7 rst data_out",   DATA_OUT,   0);
    check("t7 rst data_avail", DATA_AVAIL, 0);
    check("t7 rst full",       FULL,       0);
    check("t7 rst frame_err",  FRAME_ERR,  0);
    check("t7 rst overrun",    OVERRUN,    0);
    check("t7 rst busy",       BUSY,       0);
    check("t7 rst count",      COUNT,      0);
    exp_q.delete();
    RX = 1'b1;
    step(2);
    RST = 1'b0;
    step(4);
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1);
    read_check("t7 data after reset");
    check("t7 final count", COUNT, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
